cv32e40p_tmr_fault_monitor: RTL and testbench
=============================================

Name: cv32e40p_tmr_fault_monitor

Overview:
Sits directly downstream of the triplicated CS-register replicas, in place of a bare per-output voter. It takes the three replica copies of one output bus and produces a registered bitwise-majority result. It also flags and counts per-replica disagreements and detects a replica that stays wrong. For a persistently faulty replica it runs a request/acknowledge handshake toward the controller so that replica's state is resynchronised from the voted copy.

Parameters:
WIDTH, 32, width of each replica bus.
CNT_W, 8, width of each per-replica saturating error counter.
PERSIST, 4, consecutive faulty valid cycles that mark a replica as persistently faulty (range 1..255).
TIMEOUT, 16, maximum cycles spent in REQ without an acknowledge (range 1..255).

Ports:
clk  in  1  clock; the block uses one clock.
rst  in  1  reset, asynchronous and active-high.
valid_i  in  1  the replica inputs are meaningful this cycle.
res0_i  in  WIDTH  replica 0 output.
res1_i  in  WIDTH  replica 1 output.
res2_i  in  WIDTH  replica 2 output.
clear_i  in  1  clears the error counters and the sticky flags; releases FAIL.
resync_ack_i  in  1  controller has completed the resync.
voted_o  out  WIDTH  registered bitwise majority.
voted_valid_o  out  1  registered copy of valid_i.
mismatch_o  out  1  registered: at least one replica differed on the last valid cycle.
fault_vec_o  out  3  registered: bit k set when res_k differed from the majority.
uncorrectable_o  out  1  sticky: all three replicas pairwise different on some valid cycle.
err_cnt0_o, err_cnt1_o, err_cnt2_o  out  CNT_W each  saturating per-replica disagreement counts.
resync_req_o  out  1  resync request.
resync_id_o  out  2  replica to resync (0..2); stable while resync_req_o is high.
resync_timeout_o  out  1  sticky: a request timed out.

Behaviour:
- Reset (asynchronous, rst=1): every output is 0 and the FSM is in IDLE. Persistence counters and the timeout counter are 0.
- Vote: maj = (r0&r1)|(r1&r2)|(r0&r2). f_k = valid_i & (res_k != maj).
- Datapath latency is 1 cycle:
  - voted_o, fault_vec_o and mismatch_o (= OR of f_k) register on valid cycles and hold otherwise.
  - voted_valid_o <= valid_i on every cycle.
- uncorrectable_o: set on a valid cycle where r0!=r1, r1!=r2 and r0!=r2. It stays set until clear_i.
- Error counters: err_cnt_k increments by 1 on each cycle with f_k=1 and saturates at 2^CNT_W-1. No wrap.
- Persistence counter p_k (8 bits):
  - valid cycle with f_k=1: p_k+1, saturating at PERSIST.
  - valid cycle with f_k=0: p_k=0.
  - non-valid cycle: p_k holds.
- FSM states and transitions:
  - IDLE: if some p_k==PERSIST and the uncorrectable condition is not present this cycle, go to REQ. resync_id_o <= lowest such k and tcnt <= 0.
  - REQ: resync_req_o=1. resync_id_o is held. tcnt increments each cycle.
    - If resync_ack_i=1: go to DONE. Ack wins over timeout when both occur in the same cycle.
    - Else if tcnt==TIMEOUT-1: go to FAIL and set resync_timeout_o.
  - DONE (1 cycle): resync_req_o=0 and p[resync_id_o] <= 0. Go to IDLE next cycle.
  - FAIL: resync_req_o=0. Stay until clear_i=1, then go to IDLE.
- resync_ack_i is ignored outside REQ.
- clear_i:
  - Zeroes err_cnt_k and clears uncorrectable_o and resync_timeout_o.
  - Clear has priority over an increment or set in the same cycle: the counter reads 0 next cycle and the flag is 0.
  - Does not abort REQ or alter p_k.
- Reset asserted mid-REQ returns everything to reset values immediately. No ack is expected afterwards.

Test Plan:
1. Reset, then valid_i=1 with r0=r1=r2=0xA5A5A5A5 for 10 cycles -> voted_o=0xA5A5A5A5 from the cycle after the first valid. mismatch_o=0, all counters 0, resync_req_o never set.
2. r1=0xFFFF0000, r0=r2=0x12345678 for 4 valid cycles (PERSIST=4):
   - voted_o=0x12345678 and fault_vec_o=3'b010 one cycle after the first mismatch.
   - err_cnt1_o=4.
   - resync_req_o=1 with resync_id_o=1 on the cycle after the 4th mismatch.
   - ack 3 cycles later -> one DONE cycle, then IDLE. err_cnt1_o remains 4.
3. Replica 2 faulty for 3 valid cycles, 2 idle cycles, 1 more faulty valid cycle -> request raised, because p_2 holds through non-valid cycles. Repeat the test with an agreeing valid cycle in place of the idle cycles -> no request.
4. Request outstanding, no ack, TIMEOUT=16 -> resync_req_o drops after 16 cycles and resync_timeout_o=1 stays set. Then clear_i=1 -> flag 0 and FSM returns to IDLE.
5. r0=1, r1=2, r2=4 on a valid cycle -> voted_o=0, uncorrectable_o=1, no resync request. clear_i together with another mismatch -> uncorrectable_o=0 and counters 0 next cycle.
6. Single replica faulty for 300 cycles with CNT_W=8 -> that counter saturates at 255. Assert rst mid-REQ -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/cv32e40p_tmr_fault_monitor.sv
// Majority voter and fault monitor for one triplicated CS-register output.
// Drives a registered vote, per-replica fault flags and counters, and a
// request/acknowledge resync handshake for a replica that stays wrong.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   valid_i             replica inputs meaningful this cycle
//   res0_i..res2_i      replica buses
//   clear_i             clears counters and sticky flags, releases FAIL
//   resync_ack_i        controller finished the resync
//   voted_o             registered bitwise majority
//   voted_valid_o       registered valid_i
//   mismatch_o          some replica differed on the last valid cycle
//   fault_vec_o         per-replica disagreement on the last valid cycle
//   uncorrectable_o     sticky: all three replicas pairwise different
//   err_cnt0_o..2_o     saturating per-replica disagreement counts
//   resync_req_o        resync request
//   resync_id_o         replica to resync
//   resync_timeout_o    sticky: a request timed out
module cv32e40p_tmr_fault_monitor #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PERSIST = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] res0_i,
    input  logic [WIDTH-1:0] res1_i,
    input  logic [WIDTH-1:0] res2_i,
    input  logic             clear_i,
    input  logic             resync_ack_i,
    output logic [WIDTH-1:0] voted_o,
    output logic             voted_valid_o,
    output logic             mismatch_o,
    output logic [2:0]       fault_vec_o,
    output logic             uncorrectable_o,
    output logic [CNT_W-1:0] err_cnt0_o,
    output logic [CNT_W-1:0] err_cnt1_o,
    output logic [CNT_W-1:0] err_cnt2_o,
    output logic             resync_req_o,
    output logic [1:0]       resync_id_o,
    output logic             resync_timeout_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        FAIL
    } state_t;

    localparam logic [7:0]       PMAX  = 8'(PERSIST);
    localparam logic [7:0]       TLAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CMAX  = '1;

    state_t                  state_q;
    logic [7:0]              tcnt_q;
    logic [WIDTH-1:0]        maj;
    logic [2:0]              flt;
    logic                    unc_now;
    logic [2:0][7:0]         p_q;
    logic [2:0][7:0]         p_nxt;
    logic [2:0]              hit;
    logic [1:0]              lo_id;
    logic [2:0][CNT_W-1:0]   cnt_q;

    assign err_cnt0_o = cnt_q[0];
    assign err_cnt1_o = cnt_q[1];
    assign err_cnt2_o = cnt_q[2];

    // Persistence is judged on the post-update count so a request
    // follows the cycle that completes the faulty run.
    always_comb begin
        maj = (res0_i & res1_i) | (res1_i & res2_i) |
              (res0_i & res2_i);
        flt[0] = valid_i && (res0_i != maj);
        flt[1] = valid_i && (res1_i != maj);
        flt[2] = valid_i && (res2_i != maj);
        unc_now = valid_i && (res0_i != res1_i) &&
                  (res1_i != res2_i) && (res0_i != res2_i);
        for (int k = 0; k < 3; k++) begin
            p_nxt[k] = p_q[k];
            if (valid_i) begin
                if (!flt[k]) begin
                    p_nxt[k] = '0;
                end else if (p_q[k] != PMAX) begin
                    p_nxt[k] = p_q[k] + 8'd1;
                end
            end
            hit[k] = (p_nxt[k] == PMAX);
        end
    end

    always_comb begin
        if (hit[0]) begin
            lo_id = 2'd0;
        end else if (hit[1]) begin
            lo_id = 2'd1;
        end else begin
            lo_id = 2'd2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            voted_o         <= '0;
            voted_valid_o   <= 1'b0;
            mismatch_o      <= 1'b0;
            fault_vec_o     <= '0;
            uncorrectable_o <= 1'b0;
            cnt_q           <= '0;
            p_q             <= '0;
        end else begin
            voted_valid_o <= valid_i;
            if (valid_i) begin
                voted_o     <= maj;
                fault_vec_o <= flt;
                mismatch_o  <= |flt;
            end
            if (clear_i) begin
                uncorrectable_o <= 1'b0;
            end else if (unc_now) begin
                uncorrectable_o <= 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
                if (clear_i) begin
                    cnt_q[k] <= '0;
                end else if (flt[k] && cnt_q[k] != CMAX) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
                // The resynced replica restarts its persistence run.
                if (state_q == DONE && resync_id_o == 2'(k)) begin
                    p_q[k] <= '0;
                end else begin
                    p_q[k] <= p_nxt[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            tcnt_q           <= '0;
            resync_req_o     <= 1'b0;
            resync_id_o      <= '0;
            resync_timeout_o <= 1'b0;
        end else begin
            if (clear_i) begin
                resync_timeout_o <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    // A fully disagreeing cycle gives no trustworthy
                    // copy to resync from, so hold off.
                    if (|hit && !unc_now) begin
                        state_q      <= REQ;
                        resync_req_o <= 1'b1;
                        resync_id_o  <= lo_id;
                        tcnt_q       <= '0;
                    end
                end
                REQ: begin
                    tcnt_q <= tcnt_q + 8'd1;
                    if (resync_ack_i) begin
                        state_q      <= DONE;
                        resync_req_o <= 1'b0;
                    end else if (tcnt_q == TLAST) begin
                        state_q      <= FAIL;
                        resync_req_o <= 1'b0;
                        if (!clear_i) begin
                            resync_timeout_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                FAIL: begin
                    if (clear_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40p_tmr_fault_monitor.sv
// Self-checking bench for cv32e40p_tmr_fault_monitor.
// Directed scenarios plus random traffic against a behavioural model.
module tb_cv32e40p_tmr_fault_monitor;

    localparam int PERSIST = 4;
    localparam int TIMEOUT = 16;
    localparam int CMAXI   = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [31:0] res0_i, res1_i, res2_i;
    logic        clear_i, resync_ack_i;
    logic [31:0] voted_o;
    logic        voted_valid_o, mismatch_o;
    logic [2:0]  fault_vec_o;
    logic        uncorrectable_o;
    logic [7:0]  err_cnt0_o, err_cnt1_o, err_cnt2_o;
    logic        resync_req_o;
    logic [1:0]  resync_id_o;
    logic        resync_timeout_o;

    cv32e40p_tmr_fault_monitor #(
        .WIDTH(32), .CNT_W(8),
        .PERSIST(PERSIST), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i),
        .res0_i(res0_i), .res1_i(res1_i), .res2_i(res2_i),
        .clear_i(clear_i), .resync_ack_i(resync_ack_i),
        .voted_o(voted_o), .voted_valid_o(voted_valid_o),
        .mismatch_o(mismatch_o), .fault_vec_o(fault_vec_o),
        .uncorrectable_o(uncorrectable_o),
        .err_cnt0_o(err_cnt0_o), .err_cnt1_o(err_cnt1_o),
        .err_cnt2_o(err_cnt2_o),
        .resync_req_o(resync_req_o), .resync_id_o(resync_id_o),
        .resync_timeout_o(resync_timeout_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] e_voted;
    logic        e_vv, e_mm, e_unc, e_req, e_tmo;
    logic [2:0]  e_fv;
    int          e_cnt [3];
    int          e_id;
    int          run [3];   // consecutive faulty valid cycles
    int          mode;      // 0 idle, 1 waiting ack, 2 done, 3 failed
    int          age;       // cycles spent waiting for ack

    function automatic void model_reset();
        e_voted = '0; e_vv = 0; e_mm = 0; e_unc = 0;
        e_req = 0; e_tmo = 0; e_fv = '0; e_id = 0;
        mode = 0; age = 0;
        for (int k = 0; k < 3; k++) begin
            e_cnt[k] = 0;
            run[k] = 0;
        end
    endfunction

    function automatic void model_step();
        logic [31:0] r [3];
        logic [31:0] maj;
        logic [2:0]  flt;
        logic        unc;
        int          ones;
        int          pick;
        r[0] = res0_i; r[1] = res1_i; r[2] = res2_i;
        maj = '0;
        for (int b = 0; b < 32; b++) begin
            ones = int'(r[0][b]) + int'(r[1][b]) + int'(r[2][b]);
            maj[b] = (ones >= 2);
        end
        for (int k = 0; k < 3; k++)
            flt[k] = valid_i && (r[k] != maj);
        unc = valid_i && (r[0] != r[1]) && (r[1] != r[2])
              && (r[0] != r[2]);
        for (int k = 0; k < 3; k++)
            if (valid_i) run[k] = flt[k] ? run[k] + 1 : 0;
        if (mode == 2) run[e_id] = 0;
        if (valid_i) begin
            e_voted = maj; e_fv = flt; e_mm = |flt;
        end
        e_vv = valid_i;
        e_unc = clear_i ? 1'b0 : (e_unc | unc);
        for (int k = 0; k < 3; k++) begin
            if (clear_i) e_cnt[k] = 0;
            else if (flt[k] && e_cnt[k] < CMAXI) e_cnt[k]++;
        end
        if (clear_i) e_tmo = 0;
        case (mode)
            0: begin
                pick = -1;
                for (int k = 2; k >= 0; k--)
                    if (run[k] >= PERSIST) pick = k;
                if (pick >= 0 && !unc) begin
                    mode = 1; e_req = 1; e_id = pick; age = 0;
                end
            end
            1: begin
                age++;
                if (resync_ack_i) begin
                    mode = 2; e_req = 0;
                end else if (age == TIMEOUT) begin
                    mode = 3; e_req = 0;
                    if (!clear_i) e_tmo = 1;
                end
            end
            2: mode = 0;
            default: if (clear_i) mode = 0;
        endcase
    endfunction

    function automatic logic [65:0] obs();
        return {voted_o, voted_valid_o, mismatch_o, fault_vec_o,
                uncorrectable_o, err_cnt0_o, err_cnt1_o,
                err_cnt2_o, resync_req_o, resync_id_o,
                resync_timeout_o};
    endfunction

    function automatic logic [65:0] expv();
        return {e_voted, e_vv, e_mm, e_fv, e_unc,
                8'(e_cnt[0]), 8'(e_cnt[1]), 8'(e_cnt[2]),
                e_req, 2'(e_id), e_tmo};
    endfunction

    task automatic tick(input logic v,
                        input logic [31:0] a, b, c,
                        input logic clr = 1'b0,
                        input logic ack = 1'b0);
        valid_i = v; res0_i = a; res1_i = b; res2_i = c;
        clear_i = clr; resync_ack_i = ack;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        valid_i = 0; res0_i = '0; res1_i = '0; res2_i = '0;
        clear_i = 0; resync_ack_i = 0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_cmp++;
        if (obs() !== 66'd0) begin
            n_err++;
            $display("FAIL reset: got %h want 0", obs());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_agree();
        for (int i = 0; i < 10; i++) begin
            tick(1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL agree[%0d]: got %h want %h",
                         i, obs(), expv());
            end
            n_cmp++;
            if (voted_o !== 32'hA5A5A5A5 || mismatch_o !== 1'b0
                || resync_req_o !== 1'b0) begin
                n_err++;
                $display("FAIL agree_vote: got %h/%b/%b want a5a5a5a5/0/0",
                         voted_o, mismatch_o, resync_req_o);
            end
        end
    endtask

    task automatic test_persist();
        for (int i = 0; i < 4; i++) begin
            tick(1, 32'h12345678, 32'hFFFF0000, 32'h12345678);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL persist[%0d]: got %h want %h",
                         i, obs(), expv());
            end
            if (i == 0) begin
                n_cmp++;
                if (voted_o !== 32'h12345678
                    || fault_vec_o !== 3'b010) begin
                    n_err++;
                    $display("FAIL persist_first: got %h/%b want 12345678/010",
                             voted_o, fault_vec_o);
                end
            end
        end
        n_cmp++;
        if (err_cnt1_o !== 8'd4 || resync_req_o !== 1'b1
            || resync_id_o !== 2'd1) begin
            n_err++;
            $display("FAIL persist_req: got cnt=%0d req=%b id=%0d want 4/1/1",
                     err_cnt1_o, resync_req_o, resync_id_o);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 32'h12345678, 32'hFFFF0000, 32'h12345678,
                 1'b0, i == 2);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL persist_ack[%0d]: got %h want %h",
                         i, obs(), expv());
            end
        end
        n_cmp++;
        if (resync_req_o !== 1'b0 || err_cnt1_o !== 8'd4) begin
            n_err++;
            $display("FAIL persist_done: got req=%b cnt=%0d want 0/4",
                     resync_req_o, err_cnt1_o);
        end
    endtask

    task automatic test_hold();
        logic [31:0] x, y;
        logic        got;
        for (int pass = 0; pass < 2; pass++) begin
            x = $urandom;
            y = x ^ ($urandom | 32'h1);
            for (int i = 0; i < 3; i++) tick(1, x, x, y);
            if (pass == 0) begin
                tick(0, x, x, y);
                tick(0, x, x, y);
            end else begin
                tick(1, x, x, x);
            end
            tick(1, x, x, y);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL hold[%0d]: got %h want %h",
                         pass, obs(), expv());
            end
            got = resync_req_o;
            n_cmp++;
            if (got !== (pass == 0)
                || (pass == 0 && resync_id_o !== 2'd2)) begin
                n_err++;
                $display("FAIL hold_req[%0d]: got req=%b id=%0d want %b/2",
                         pass, got, resync_id_o, pass == 0);
            end
            tick(0, x, x, x, 1'b0, 1'b1);
            tick(0, x, x, x);
            tick(1, x, x, x);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL hold_end[%0d]: got %h want %h",
                         pass, obs(), expv());
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] x, y;
        int hi;
        x = $urandom;
        y = ~x;
        for (int i = 0; i < 4; i++) tick(1, y, x, x);
        hi = resync_req_o ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick(0, y, x, x);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL timeout_run[%0d]: got %h want %h",
                         i, obs(), expv());
            end
            if (!resync_req_o) break;
            hi++;
        end
        n_cmp++;
        if (hi != TIMEOUT || resync_timeout_o !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_len: got %0d cycles tmo=%b want %0d/1",
                     hi, resync_timeout_o, TIMEOUT);
        end
        tick(0, y, x, x);
        tick(1, x, x, x);
        tick(0, x, x, x, 1'b1);
        n_cmp++;
        if (resync_timeout_o !== 1'b0 || err_cnt0_o !== 8'd0) begin
            n_err++;
            $display("FAIL timeout_clear: got tmo=%b cnt=%0d want 0/0",
                     resync_timeout_o, err_cnt0_o);
        end
        tick(0, x, x, x);
        tick(0, x, x, x);
        n_cmp++;
        if (obs() !== expv() || resync_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_idle: got %h want %h",
                     obs(), expv());
        end
    endtask

    task automatic test_uncorrectable();
        tick(1, 32'd1, 32'd2, 32'd4);
        n_cmp++;
        if (voted_o !== 32'd0 || uncorrectable_o !== 1'b1
            || fault_vec_o !== 3'b111 || resync_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL unc_set: got %h/%b/%b/%b want 0/1/111/0",
                     voted_o, uncorrectable_o, fault_vec_o,
                     resync_req_o);
        end
        tick(1, 32'd5, 32'd5, 32'd6, 1'b1);
        n_cmp++;
        if (uncorrectable_o !== 1'b0 || err_cnt0_o !== 8'd0
            || err_cnt2_o !== 8'd0 || fault_vec_o !== 3'b100) begin
            n_err++;
            $display("FAIL unc_clear: got %b/%0d/%0d/%b want 0/0/0/100",
                     uncorrectable_o, err_cnt0_o, err_cnt2_o,
                     fault_vec_o);
        end
        tick(1, 32'd5, 32'd5, 32'd5);
        tick(0, 32'd5, 32'd5, 32'd5);
        n_cmp++;
        if (obs() !== expv() || resync_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL unc_end: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_saturate();
        logic [31:0] x, y;
        x = $urandom;
        y = x ^ 32'h0000_8000;
        for (int i = 0; i < 300; i++) begin
            tick(1, x, x, y);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL sat_run[%0d]: got %h want %h",
                         i, obs(), expv());
            end
        end
        n_cmp++;
        if (err_cnt2_o !== 8'd255) begin
            n_err++;
            $display("FAIL sat_cnt: got %0d want 255", err_cnt2_o);
        end
        tick(0, x, x, y, 1'b1);
        tick(0, x, x, y);
        tick(0, x, x, y);
        n_cmp++;
        if (resync_req_o !== 1'b1 || resync_id_o !== 2'd2) begin
            n_err++;
            $display("FAIL sat_rereq: got req=%b id=%0d want 1/2",
                     resync_req_o, resync_id_o);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (obs() !== 66'd0) begin
            n_err++;
            $display("FAIL async_rst: got %h want 0", obs());
        end
        @(negedge clk);
        rst = 1'b0;
        tick(0, x, x, y);
        n_cmp++;
        if (obs() !== expv() || resync_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL post_rst: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_random();
        logic [31:0] base, a, b, c, m1, m2;
        int bad, kind;
        bad = 3;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) bad = $urandom_range(0, 3);
            base = $urandom;
            a = base; b = base; c = base;
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                m1 = ($urandom & ~32'h2) | 32'h1;
                m2 = $urandom | 32'h2;
                b = base ^ m1;
                c = base ^ m2;
            end else if (bad < 3 && kind < 14) begin
                m1 = $urandom | 32'h1;
                if (bad == 0) a = base ^ m1;
                else if (bad == 1) b = base ^ m1;
                else c = base ^ m1;
            end
            tick($urandom_range(0, 3) != 0, a, b, c,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) == 0);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL random[%0d]: got %h want %h",
                         i, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_agree();
        test_persist();
        test_hold();
        test_timeout();
        test_uncorrectable();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
